// File: rtl/simplez_kbd.sv
// simplez_kbd: 8N1 serial receiver for the Simplez CPU.
// It has a one-byte holding register, a status register read at 506 and a
// data register read at 507. Reading the data register clears all flags.
module simplez_kbd #(
  parameter int unsigned BAUD = 104
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx,
  input  logic        status_cs,
  input  logic        data_cs,
  output logic [11:0] dout,
  output logic        rcv
);

  // Counter reload values. Each wait ends when the counter reaches zero,
  // so a load of N-1 gives a wait of N cycles.
  localparam logic [15:0] BIT_LEN  = 16'(BAUD - 1);
  localparam logic [15:0] HALF_LEN = 16'((BAUD >> 1) - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [2:0]  bidx, bidx_nxt;
  logic        rx_m, rxs, rxs_d;
  logic [7:0]  shift, hold;
  logic        ready, ovr, ferr;
  logic        shift_en, frame_ok, frame_bad, tick;

  assign tick = (cnt == 16'd0);
  assign rcv  = ready;

  // Two-flop synchroniser, plus a delayed copy of rxs for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_m  <= rx;
      rxs   <= rx_m;
      rxs_d <= rxs;
    end
  end

  // FSM state, bit timer and bit index registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= 16'd0;
      bidx  <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bidx  <= bidx_nxt;
    end
  end

  // Next state. The counter is reloaded on every state entry and after
  // every data bit. The frame result is flagged in the cycle of the stop
  // sample.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - 16'd1;
    bidx_nxt  = bidx;
    shift_en  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = cnt;
        if (rxs_d && !rxs) begin
          state_nxt = START;
          cnt_nxt   = HALF_LEN;
        end
      end
      START: begin
        if (tick) begin
          if (!rxs) begin
            state_nxt = DATA;
            cnt_nxt   = BIT_LEN;
            bidx_nxt  = 3'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          cnt_nxt  = BIT_LEN;
          if (bidx == 3'd7) state_nxt = STOP;
          else              bidx_nxt  = bidx + 3'd1;
        end
      end
      STOP: begin
        if (tick) begin
          state_nxt = IDLE;
          frame_ok  = rxs;
          frame_bad = !rxs;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register. Bits arrive LSB first, so new bits enter at the top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         shift <= 8'd0;
    else if (shift_en) shift <= {rxs, shift[7:1]};
  end

  // Holding register and flags. A data read in the same cycle as frame
  // completion counts as consuming the old byte first. The new byte is
  // then loaded without overrun, and ferr reflects only the new frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold  <= 8'd0;
      ready <= 1'b0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
    end else if (frame_ok) begin
      if (data_cs || !ready) begin
        hold  <= shift;
        ready <= 1'b1;
      end else begin
        ovr <= 1'b1;
      end
      if (data_cs) begin
        ovr  <= 1'b0;
        ferr <= 1'b0;
      end
    end else if (frame_bad) begin
      ferr <= 1'b1;
      if (data_cs) begin
        ready <= 1'b0;
        ovr   <= 1'b0;
      end
    end else if (data_cs) begin
      ready <= 1'b0;
      ovr   <= 1'b0;
      ferr  <= 1'b0;
    end
  end

  // Registered read port. If both strobes are active, data wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          dout <= 12'h000;
    else if (data_cs)   dout <= {4'b0, hold};
    else if (status_cs) dout <= {9'b0, ferr, ovr, ready};
  end

endmodule

// File: tb/tb_simplez_kbd.sv
// Bench for simplez_kbd: directed scenarios plus randomized frames, all
// checked against a frame-level model of the receiver's registers.
module tb_simplez_kbd;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rstn, rx, status_cs, data_cs;
  logic [11:0] dout;
  logic        rcv;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the CPU-visible state.
  logic       m_ready, m_ovr, m_ferr;
  logic [7:0] m_hold;
  logic [11:0] m_dout;
  logic        pre_rcv;
  logic [11:0] coll_dout, coll_exp;

  simplez_kbd #(.BAUD(B)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .status_cs(status_cs),
    .data_cs(data_cs), .dout(dout), .rcv(rcv)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic model_reset;
    m_ready = 0; m_ovr = 0; m_ferr = 0; m_hold = 8'h00; m_dout = 12'h000;
  endtask

  // Effect of one completed frame, optionally with a data read in the
  // same cycle.
  task automatic model_frame(input logic [7:0] b, input logic stopv, input logic rd);
    if (rd) begin
      m_dout = {4'b0, m_hold};
      if (stopv) begin
        m_hold = b; m_ready = 1; m_ovr = 0; m_ferr = 0;
      end else begin
        m_ready = 0; m_ovr = 0; m_ferr = 1;
      end
    end else if (stopv) begin
      if (m_ready) m_ovr = 1;
      else begin m_hold = b; m_ready = 1; end
    end else begin
      m_ferr = 1;
    end
  endtask

  // Issue one bus cycle. Return both what the DUT drove and what the model
  // expects, and apply the read side effects to the model.
  task automatic cpu_read(input logic s, input logic d,
                          output logic [11:0] v, output logic [11:0] e);
    if (d) begin
      e = {4'b0, m_hold}; m_ready = 0; m_ovr = 0; m_ferr = 0;
    end else if (s) e = {9'b0, m_ferr, m_ovr, m_ready};
    else            e = m_dout;
    m_dout = e;
    status_cs = s; data_cs = d;
    tick;
    status_cs = 0; data_cs = 0;
    v = dout;
  endtask

  // Drive one 8N1 frame over 10*B cycles. The line is left at the stop
  // level. When collide is set, data_cs is pulsed in the stop-sample cycle.
  // Start detection takes 3 cycles and B/2 more reach mid-start-bit, so the
  // stop sample lands on edge 3 + B/2 + 9*B = 10*B - 1.
  task automatic send_frame(input logic [7:0] b, input logic stopv, input bit collide);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    coll_exp = {4'b0, m_hold};
    for (int k = 0; k < 10*B; k++) begin
      rx = fr[k/B];
      if (collide && k == 10*B-2) data_cs = 1;
      tick;
      if (k == 10*B-3) pre_rcv = rcv;
      if (collide && k == 10*B-2) begin
        data_cs = 0;
        coll_dout = dout;
      end
    end
    model_frame(b, stopv, collide);
  endtask

  task automatic test_reset;
    logic [11:0] v, e;
    rstn = 0; rx = 1; status_cs = 0; data_cs = 0;
    model_reset;
    repeat (3) tick;
    n_tests++;
    if (dout !== 12'h000 || rcv !== 1'b0) begin
      n_fail++; $display("FAIL reset: dout=%h rcv=%b want 000/0", dout, rcv);
    end
    rstn = 1; tick;
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL reset_status: got %h want %h", v, e); end
  endtask

  task automatic test_basic;
    logic [11:0] v, e;
    send_frame(8'h41, 1, 0);
    n_tests++;
    if (pre_rcv !== 1'b0 || rcv !== 1'b1) begin
      n_fail++; $display("FAIL basic_timing: rcv before=%b after=%b want 0/1", pre_rcv, rcv);
    end
    tick;
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== 12'h001 || v !== e) begin n_fail++; $display("FAIL basic_status: got %h want 001", v); end
    cpu_read(0, 1, v, e);
    n_tests++;
    if (v !== 12'h041 || v !== e || rcv !== 1'b0) begin
      n_fail++; $display("FAIL basic_data: got %h rcv=%b want 041/0", v, rcv);
    end
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== 12'h000) begin n_fail++; $display("FAIL basic_status2: got %h want 000", v); end
  endtask

  task automatic test_glitch;
    logic [11:0] v, e;
    rx = 0; repeat (3) tick;
    rx = 1; repeat (4*B) tick;
    n_tests++;
    if (rcv !== m_ready || dout !== m_dout) begin
      n_fail++; $display("FAIL glitch: rcv=%b dout=%h want %b/%h", rcv, dout, m_ready, m_dout);
    end
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== 12'h000) begin n_fail++; $display("FAIL glitch_status: got %h want 000", v); end
  endtask

  task automatic test_overrun;
    logic [11:0] v, e;
    send_frame(8'h55, 1, 0);
    send_frame(8'hAA, 1, 0);
    tick;
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== 12'h003 || v !== e) begin n_fail++; $display("FAIL ovr_status: got %h want 003", v); end
    cpu_read(0, 1, v, e);
    n_tests++;
    if (v !== 12'h055) begin n_fail++; $display("FAIL ovr_data: got %h want 055", v); end
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== 12'h000) begin n_fail++; $display("FAIL ovr_status2: got %h want 000", v); end
  endtask

  task automatic test_break;
    logic [11:0] v, e;
    send_frame(8'h3C, 0, 0);
    tick;
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== 12'h004 || rcv !== 1'b0) begin
      n_fail++; $display("FAIL ferr_status: got %h rcv=%b want 004/0", v, rcv);
    end
    repeat (3*B) tick;
    rx = 1; repeat (2*B) tick;
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== 12'h004 || rcv !== 1'b0) begin
      n_fail++; $display("FAIL break_noframe: got %h rcv=%b want 004/0", v, rcv);
    end
    send_frame(8'h12, 1, 0);
    tick;
    cpu_read(0, 1, v, e);
    n_tests++;
    if (v !== 12'h012) begin n_fail++; $display("FAIL break_data: got %h want 012", v); end
  endtask

  task automatic test_collision;
    logic [11:0] v, e;
    send_frame(8'h21, 1, 0);
    tick; tick;
    send_frame(8'h22, 1, 1);
    n_tests++;
    if (coll_dout !== 12'h021 || coll_dout !== coll_exp) begin
      n_fail++; $display("FAIL coll_dout: got %h want 021", coll_dout);
    end
    n_tests++;
    if (rcv !== 1'b1) begin n_fail++; $display("FAIL coll_rcv: got %b want 1", rcv); end
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== 12'h001) begin n_fail++; $display("FAIL coll_status: got %h want 001", v); end
    cpu_read(0, 1, v, e);
    n_tests++;
    if (v !== 12'h022) begin n_fail++; $display("FAIL coll_data: got %h want 022", v); end
  endtask

  task automatic test_reset_mid;
    logic [11:0] v, e;
    logic [9:0]  fr;
    fr = {1'b1, 8'h7E, 1'b0};
    for (int k = 0; k < 5*B + 2; k++) begin
      rx = fr[k/B];
      tick;
    end
    rstn = 0; #2;
    n_tests++;
    if (dout !== 12'h000 || rcv !== 1'b0) begin
      n_fail++; $display("FAIL midreset: dout=%h rcv=%b want 000/0", dout, rcv);
    end
    rx = 1; repeat (3) tick;
    rstn = 1; model_reset; repeat (3) tick;
    send_frame(8'h7E, 1, 0);
    tick;
    cpu_read(0, 1, v, e);
    n_tests++;
    if (v !== 12'h07E) begin n_fail++; $display("FAIL midreset_data: got %h want 07e", v); end
  endtask

  task automatic test_random;
    logic [11:0] v, e;
    logic [7:0]  b;
    logic        stopv, s, d;
    int          nr;
    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      stopv = ($urandom_range(0, 6) != 0);
      send_frame(b, stopv, 0);
      n_tests++;
      if (rcv !== m_ready) begin
        n_fail++; $display("FAIL rand_rcv[%0d]: got %b want %b", i, rcv, m_ready);
      end
      if (!stopv) begin rx = 1; repeat (3) tick; end
      if (stopv && $urandom_range(0, 1) == 0) continue;
      nr = $urandom_range(0, 3);
      for (int j = 0; j < nr; j++) begin
        s = 1'($urandom); d = 1'($urandom);
        cpu_read(s, d, v, e);
        n_tests++;
        if (v !== e) begin
          n_fail++; $display("FAIL rand_read[%0d.%0d] s=%b d=%b: got %h want %h", i, j, s, d, v, e);
        end
      end
    end
    tick;
    cpu_read(1, 0, v, e);
    n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL rand_final_status: got %h want %h", v, e); end
    cpu_read(0, 1, v, e);
    n_tests++;
    if (v !== e) begin n_fail++; $display("FAIL rand_final_data: got %h want %h", v, e); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_overrun;
    test_break;
    test_collision;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
